// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
//
// Purpose:
//   Definitions shared by the parity transmitter and the receiving checker.
//   The frame FSM encoding, the parity-mode constants and a helper that turns
//   the raw XOR reduction into the final transmitted parity bit all live here.
//   Both ends therefore agree on what "even" and "odd" mean.
//
// Contents:
//   state_t     - frame FSM states (IDLE, SHIFT, PARITY)
//   PAR_EVEN    - parity mode 0: parity bit = ^data
//   PAR_ODD     - parity mode 1: parity bit = ~^data
//   apply_mode  - converts an accumulated XOR into the parity bit for a mode
// ---------------------------------------------------------------------------
package parity_pkg;

  // Frame FSM states. The encodings are fixed so that the checker side can
  // decode the same values.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Parity-mode selectors.
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // The accumulator always holds the plain XOR of the data bits. Odd mode
  // inverts that value, which gives the XNOR reduction, so a frame of all
  // zeros carries a 1.
  function automatic logic apply_mode(input logic acc, input bit mode);
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/parity_gen.sv
// ---------------------------------------------------------------------------
// parity_gen
//
// Purpose:
//   One step of the running parity calculation. It folds one data bit into
//   the accumulated parity. This block only performs the XOR. The transmitter
//   applies the odd-mode inversion when it drives the parity bit out.
//
// Ports:
//   acc       in   1  parity accumulated over the bits sent so far
//   data_bit  in   1  bit being transmitted this cycle
//   next_p    out  1  accumulated parity including data_bit
// ---------------------------------------------------------------------------
module parity_gen (
  input  logic acc,
  input  logic data_bit,
  output logic next_p
);

  assign next_p = acc ^ data_bit;

endmodule

// File: rtl/parity_tx_serial.sv
// ---------------------------------------------------------------------------
// parity_tx_serial
//
// Purpose:
//   Serial transmitter with a valid/ready handshake. It accepts a parallel
//   word, sends it out one bit per clock with the LSB first, and then sends
//   one parity bit. A frame therefore has WIDTH+1 cycles with s_valid high.
//   The transmitter can accept a new word while the parity bit of the
//   current frame is on the line. With a continuous source, frames follow
//   each other with no gap.
//
// Parameters:
//   WIDTH  data word width in bits (>= 1)
//   ODD    parity mode: PAR_EVEN (bit = ^data) or PAR_ODD (bit = ~^data)
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   in_data   in   WIDTH  word to transmit, sampled on the accepting edge
//   in_valid  in   1      source has a word
//   in_ready  out  1      transmitter can take a word this cycle
//   s         out  1      serial data or parity bit (registered)
//   s_valid   out  1      s carries a bit this cycle (registered)
//   s_last    out  1      s carries the parity bit (registered)
// ---------------------------------------------------------------------------
module parity_tx_serial
  import parity_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit ODD   = PAR_EVEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s,
  output logic             s_valid,
  output logic             s_last
);

  // The counter must reach WIDTH, so it needs $clog2(WIDTH+1) bits.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             parity;
  logic             next_p;
  logic [CNT_W-1:0] count;
  logic             accept;

  // in_ready depends only on the state. A word can be accepted in IDLE and
  // also in PARITY, which allows back-to-back frames. A source that waits
  // for in_ready before raising in_valid therefore adds no combinational
  // loop.
  assign in_ready = (state != SHIFT);
  assign accept   = in_valid & in_ready;

  // Shifting right moves the next bit into position 0. This is also correct
  // for WIDTH = 1, where no bit follows.
  assign shreg_next = shreg >> 1;

  // Running parity over the bit that is on the line this cycle.
  parity_gen u_parity_gen (
    .acc      (parity),
    .data_bit (shreg[0]),
    .next_p   (next_p)
  );

  // Frame FSM with the datapath and the registered outputs.
  // The outputs are loaded one edge early with the bit for the following
  // cycle, so s always equals shreg[0] while in SHIFT. When a word is
  // accepted, in_data[0] goes straight onto s. On the edge that leaves the
  // last data bit, the complete parity, with the mode applied, goes onto s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      parity  <= 1'b0;
      count   <= '0;
      s       <= 1'b0;
      s_valid <= 1'b0;
      s_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            shreg   <= in_data;
            parity  <= 1'b0;
            count   <= '0;
            s       <= in_data[0];
            s_valid <= 1'b1;
            s_last  <= 1'b0;
          end
        end

        SHIFT: begin
          shreg  <= shreg_next;
          parity <= next_p;
          count  <= count + CNT_W'(1);
          if (count == LAST_CNT) begin
            // next_p already includes the last data bit.
            state   <= PARITY;
            s       <= apply_mode(next_p, ODD);
            s_valid <= 1'b1;
            s_last  <= 1'b1;
          end else begin
            s       <= shreg_next[0];
            s_valid <= 1'b1;
            s_last  <= 1'b0;
          end
        end

        PARITY: begin
          if (accept) begin
            // Back-to-back: the next frame starts immediately after this
            // parity bit, with no idle cycle.
            state   <= SHIFT;
            shreg   <= in_data;
            parity  <= 1'b0;
            count   <= '0;
            s       <= in_data[0];
            s_valid <= 1'b1;
            s_last  <= 1'b0;
          end else begin
            state   <= IDLE;
            s       <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          s       <= 1'b0;
          s_valid <= 1'b0;
          s_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/parity_tx_serial.md
# parity_tx_serial

Serial transmitter that accepts a parallel word over a valid/ready handshake, shifts it out LSB-first one bit per clock, and appends one parity bit computed by XOR/XNOR reduction. It is the generating end of the two-input equality/parity-check gate family: a downstream XNOR-based checker recomputes parity over the received bits and compares it with the appended bit. It sits between a word source and a 1-bit serial link.

## Interface
- WIDTH, 4, data word width in bits (≥1)
- ODD, 0, parity mode: 0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  word to transmit, sampled on handshake
- in_valid  input  1  source has a word
- in_ready  output  1  block can accept a word this cycle
- s  output  1  serial data/parity bit
- s_valid  output  1  s carries a bit this cycle
- s_last  output  1  s carries the parity bit (final bit of frame)

## Operation
- One clock; reset is asynchronous and active-high.
- FSM states: IDLE, SHIFT, PARITY.
- Handshake: word accepted on a rising edge where in_valid & in_ready. in_data must be stable only in that cycle.
- in_ready = 1 in IDLE and PARITY, 0 in SHIFT (decoded from state).
- IDLE: s = 0, s_valid = 0, s_last = 0. On accept: load shift register with in_data, initialize parity accumulator, bit counter = 0, go to SHIFT.
- SHIFT: s = shreg[0], s_valid = 1, s_last = 0. Each edge: shift right, parity ^= shreg[0], counter + 1. After WIDTH bits go to PARITY.
- PARITY: s = accumulated parity (inverted if ODD = 1), s_valid = 1, s_last = 1. Next edge: if accept then reload and go to SHIFT (back-to-back), else IDLE.
- Counter width $clog2(WIDTH+1); no wrap beyond WIDTH.
- in_valid while in_ready = 0 is ignored; the source must hold the word.
- Outputs s, s_valid, and s_last are registered; in_ready is combinational from state only, not from in_valid.

## Timing
- Reset (asserted, asynchronous): state IDLE, shreg 0, parity 0, counter 0; s = 0, s_valid = 0, s_last = 0, in_ready = 1. in_valid is ignored while reset = 1.
- Reset mid-frame: outputs drop to 0 immediately and the frame is abandoned; no partial parity bit is emitted.
- Latency: word accepted at edge k → bit 0 on s during cycle k+1 → bit WIDTH-1 during cycle k+WIDTH → parity during cycle k+WIDTH+1.
- Frame length: WIDTH+1 cycles with s_valid = 1.
- Back-to-back throughput: one word per WIDTH+1 cycles, with no gap between frames.
- WIDTH = 1: one data cycle, then parity.

## Structure
- Shared package/include parity_pkg: state encodings (IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2) and parity-mode constants PAR_EVEN = 0 and PAR_ODD = 1, shared with the checker side.
- Sub-module parity_gen (combinational, 1-bit): next_p = acc ^ bit. The final XNOR for odd mode is applied at the output mux.
- Top level contains the FSM, shift register, counter, and output registers.

## Test plan
- Reset: assert reset mid-simulation with no clock edge → s = 0, s_valid = 0, s_last = 0, in_ready = 1 immediately.
- WIDTH = 4, ODD = 0, in_data = 4'b1011 → s = 1,1,0,1 then parity 1 with s_last = 1; in_ready = 0 for the 4 SHIFT cycles.
- WIDTH = 4, ODD = 1, in_data = 4'b0000 → s = 0,0,0,0 then parity 1; with in_data = 4'b1011 the parity bit is 0.
- Back-to-back: in_valid held high with words 4'b0110 then 4'b1111 → 10 consecutive s_valid cycles, both parity bits 0, second word accepted in the PARITY cycle of the first.
- Reset at the 2nd SHIFT cycle of 4'b1011 → no s_last ever asserted for that word; after release, a new word 4'b0001 is sent cleanly with parity 1.
- Stall: in_valid pulsed during SHIFT → ignored; the frame completes unchanged and no extra frame is sent.
